// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: host-side sequencer for uart_top covering TX FIFO push and frame launch, RX commit and egress, and error statistics.
// Build option UART_HOST_ERR_FILTER_EN drops RX frames flagged with framing/parity errors instead of committing them.
module uart_host_ctrl #(
    parameter int data_wd = 8,
    parameter int cnt_wd  = 8,
    parameter int tx_gap  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_en,
    input  logic [data_wd-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [data_wd-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    input  logic               tx_full,
    input  logic               tx_empty,
    input  logic               rx_full,
    input  logic               rx_empty,
    input  logic               tx_done,
    input  logic               tx_busy,
    input  logic               rx_done,
    input  logic               framing_error_flag,
    input  logic               parity_error_flag,
    input  logic [data_wd-1:0] dout,
    output logic [data_wd-1:0] din,
    output logic               tx_wr_en,
    output logic               tx_rd_en,
    output logic               rx_wr_en,
    output logic               rx_rd_en,
    output logic               tx_start,
    output logic               rx_start,
    output logic [cnt_wd-1:0]  frm_err_cnt,
    output logic [cnt_wd-1:0]  par_err_cnt,
    output logic [cnt_wd-1:0]  ovf_cnt
);
    typedef enum logic [2:0] {T_IDLE, T_POP, T_LOAD, T_START, T_BUSY, T_GAP} tx_state_t;
    localparam int gw = tx_gap > 1 ? $clog2(tx_gap) : 1;

    tx_state_t     tx_state;
    logic [gw-1:0] gap_cnt;
    logic          rd_pend;
    logic          err_drop;

`ifdef UART_HOST_ERR_FILTER_EN
    assign err_drop = framing_error_flag | parity_error_flag;
`else
    assign err_drop = 1'b0;
`endif

    // Combinational strobes are gated by rst_n so nothing leaks out while reset is held.
    assign s_ready  = rst_n & ~tx_full;
    assign tx_wr_en = s_valid & s_ready;
    assign din      = s_data;
    assign rx_wr_en = rst_n & rx_done & ~rx_full & ~err_drop;
    assign rx_rd_en = rst_n & (~m_valid | m_ready) & ~rx_empty & ~rd_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            gap_cnt  <= '0;
            tx_rd_en <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            tx_rd_en <= 1'b0;
            tx_start <= 1'b0;
            case (tx_state)
                T_IDLE:  if (~tx_empty & ~tx_busy) begin
                             tx_state <= T_POP;
                             tx_rd_en <= 1'b1;
                         end
                T_POP:   tx_state <= T_LOAD;
                T_LOAD:  begin
                             tx_state <= T_START;
                             tx_start <= 1'b1;
                         end
                T_START: tx_state <= T_BUSY;
                T_BUSY:  if (tx_done) begin
                             tx_state <= tx_gap > 0 ? T_GAP : T_IDLE;
                             gap_cnt  <= '0;
                         end
                T_GAP:   begin
                             gap_cnt <= gap_cnt + 1'b1;
                             if (gap_cnt == gw'(tx_gap - 1)) tx_state <= T_IDLE;
                         end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // rd_pend marks the cycle in which dout carries the byte popped on the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_start    <= 1'b0;
            rd_pend     <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            frm_err_cnt <= '0;
            par_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else begin
            rx_start <= rx_en;
            rd_pend  <= rx_rd_en;
            if (rd_pend) begin
                m_data  <= dout;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (rx_done & rx_full & ~&ovf_cnt) ovf_cnt <= ovf_cnt + 1'b1;
            if (rx_done & framing_error_flag & ~&frm_err_cnt) frm_err_cnt <= frm_err_cnt + 1'b1;
            if (rx_done & parity_error_flag & ~&par_err_cnt) par_err_cnt <= par_err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: self-checking bench for uart_host_ctrl with queue-based FIFO emulation and a scoreboard.
module tb_uart_host_ctrl;
`ifdef UART_HOST_ERR_FILTER_EN
    localparam bit filt = 1'b1;
`else
    localparam bit filt = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic       tx_full = 1'b0, tx_empty = 1'b1, rx_full = 1'b0, rx_empty = 1'b1;
    logic       tx_done = 1'b0, tx_busy = 1'b0, rx_done = 1'b0;
    logic       framing_error_flag = 1'b0, parity_error_flag = 1'b0;
    logic [7:0] s_data = '0, dout = '0;
    logic [7:0] din, m_data, frm_err_cnt, par_err_cnt, ovf_cnt;
    logic       s_ready, m_valid, tx_wr_en, tx_rd_en, rx_wr_en, rx_rd_en, tx_start, rx_start;

    uart_host_ctrl #(.data_wd(8), .cnt_wd(8), .tx_gap(3)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .tx_done(tx_done), .tx_busy(tx_busy), .rx_done(rx_done),
        .framing_error_flag(framing_error_flag), .parity_error_flag(parity_error_flag),
        .dout(dout), .din(din),
        .tx_wr_en(tx_wr_en), .tx_rd_en(tx_rd_en), .rx_wr_en(rx_wr_en), .rx_rd_en(rx_rd_en),
        .tx_start(tx_start), .rx_start(rx_start),
        .frm_err_cnt(frm_err_cnt), .par_err_cnt(par_err_cnt), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    int checks = 0, errors = 0;
    int cyc = 0, mv_first = -1, busy_cnt = 0;
    int e_ovf = 0, e_frm = 0, e_par = 0;
    logic force_full = 1'b0, held = 1'b0, prev_en = 1'b0;
    logic [7:0] held_data = '0;
    logic [7:0] rx_q[$], exp_q[$], tx_q[$];
    int wr_c[$], rd_c[$], st_c[$], dn_c[$], rrd_c[$];

    typedef struct packed {
        logic sv, tf, rd, rf, fe, pe, sr, tw, rw_nf, rw_f;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int x);
        return x == 255 ? 255 : x + 1;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_tx_wr_en"}, tx_wr_en, 0);
        check({tag, "_rx_wr_en"}, rx_wr_en, 0);
        check({tag, "_rx_rd_en"}, rx_rd_en, 0);
        check({tag, "_tx_rd_en"}, tx_rd_en, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_rx_start"}, rx_start, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_frm"}, frm_err_cnt, 0);
        check({tag, "_par"}, par_err_cnt, 0);
        check({tag, "_ovf"}, ovf_cnt, 0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        {rx_en, s_valid, m_ready, tx_full, rx_full, tx_done, tx_busy, rx_done} = '0;
        {framing_error_flag, parity_error_flag, force_full, held, prev_en} = '0;
        tx_empty = 1'b1; rx_empty = 1'b1; s_data = '0; dout = '0;
        rx_q.delete(); exp_q.delete(); tx_q.delete();
        wr_c.delete(); rd_c.delete(); st_c.delete(); dn_c.delete(); rrd_c.delete();
        e_ovf = 0; e_frm = 0; e_par = 0; mv_first = -1; busy_cnt = 0; cyc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One RX-side cycle: emulate the RX FIFO, predict the commit, score egress bytes.
    task automatic rx_cycle(input logic [7:0] b);
        logic rd, wr, ew;
        rx_empty = rx_q.size() == 0;
        rx_full  = force_full | (rx_q.size() >= 4);
        @(negedge clk);
        ew = rx_done & ~rx_full & ~(filt & (framing_error_flag | parity_error_flag));
        check("rx_wr_en", rx_wr_en, ew);
        check("rx_start", rx_start, prev_en);
        prev_en = rx_en;
        if (rx_done & rx_full) e_ovf = sat(e_ovf);
        if (rx_done & framing_error_flag) e_frm = sat(e_frm);
        if (rx_done & parity_error_flag) e_par = sat(e_par);
        if (held) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, held_data);
        end
        if (m_valid & ~m_ready) check("stall_rd", rx_rd_en, 0);
        if (m_valid & m_ready) begin
            check("egress_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("egress_data", m_data, exp_q.pop_front());
        end
        if (ew) exp_q.push_back(b);
        held = m_valid & ~m_ready;
        held_data = m_data;
        if (rx_rd_en) begin
            rrd_c.push_back(cyc);
            check("rx_rd_nonempty", rx_q.size() > 0, 1);
        end
        if (m_valid && mv_first < 0) mv_first = cyc;
        rd = rx_rd_en;
        wr = rx_wr_en;
        @(posedge clk); #1;
        if (rd && rx_q.size() > 0) dout = rx_q.pop_front();
        if (wr) rx_q.push_back(b);
        cyc++;
    endtask

    // One TX-side cycle: emulate the TX FIFO and a transmitter busy for 5 cycles per frame.
    task automatic tx_cycle();
        logic wr, rd, st;
        tx_empty = tx_q.size() == 0;
        tx_full  = tx_q.size() >= 4;
        @(negedge clk);
        if (tx_wr_en) begin
            wr_c.push_back(cyc);
            check("din", din, s_data);
        end
        if (tx_rd_en) begin
            rd_c.push_back(cyc);
            check("tx_rd_nonempty", tx_q.size() > 0, 1);
        end
        if (tx_start) st_c.push_back(cyc);
        if (tx_done) dn_c.push_back(cyc);
        wr = tx_wr_en; rd = tx_rd_en; st = tx_start;
        @(posedge clk); #1;
        if (wr) tx_q.push_back(din);
        if (rd && tx_q.size() > 0) void'(tx_q.pop_front());
        if (tx_done) tx_done = 1'b0;
        else if (tx_busy) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_done = 1'b1;
                tx_busy = 1'b0;
            end
        end
        if (st) begin
            tx_busy = 1'b1;
            busy_cnt = 5;
        end
        cyc++;
    endtask

    initial begin
        int c_rel;
        // fields: sv tf rd rf fe pe | s_ready tx_wr_en rx_wr(no filter) rx_wr(filter)
        vt[0] = 10'b100000_1100;
        vt[1] = 10'b110000_0000;
        vt[2] = 10'b000000_1000;
        vt[3] = 10'b001000_1011;
        vt[4] = 10'b001100_1000;
        vt[5] = 10'b001010_1010;
        vt[6] = 10'b001001_1010;
        vt[7] = 10'b101111_1100;

        #3 check_zero("reset");
        reset_dut();

        for (int i = 0; i < 8; i++) begin
            s_valid = vt[i].sv; tx_full = vt[i].tf; rx_done = vt[i].rd; rx_full = vt[i].rf;
            framing_error_flag = vt[i].fe; parity_error_flag = vt[i].pe;
            s_data = 8'($urandom);
            @(negedge clk);
            check("tbl_s_ready", s_ready, vt[i].sr);
            check("tbl_tx_wr_en", tx_wr_en, vt[i].tw);
            check("tbl_rx_wr_en", rx_wr_en, filt ? vt[i].rw_f : vt[i].rw_nf);
            check("tbl_din", din, s_data);
            @(posedge clk); #1;
        end

        reset_dut();
        rx_done = 1'b1;
        rx_cycle(8'h5A);
        rx_done = 1'b0;
        repeat (5) rx_cycle(8'h00);
        check("good_rd_cnt", rrd_c.size(), 1);
        if (rrd_c.size() > 0) check("good_rd_cyc", rrd_c[0], 1);
        check("good_mvalid_cyc", mv_first, 3);
        check("good_mdata", m_data, 8'h5A);
        rx_done = 1'b1;
        rx_cycle(8'h11);
        rx_cycle(8'h22);
        rx_done = 1'b0;
        repeat (6) rx_cycle(8'h00);
        check("bp_rd_cnt", rrd_c.size(), 1);
        m_ready = 1'b1;
        c_rel = cyc;
        rx_cycle(8'h00);
        check("bp_release_rd_cnt", rrd_c.size(), 2);
        if (rrd_c.size() == 2) check("bp_release_rd_cyc", rrd_c[1], c_rel);
        repeat (10) rx_cycle(8'h00);
        check("bp_drained", exp_q.size(), 0);

        reset_dut();
        m_ready = 1'b1;
        rx_done = 1'b1;
        parity_error_flag = 1'b1;
        rx_cycle(8'hE7);
        rx_done = 1'b0;
        parity_error_flag = 1'b0;
        repeat (5) rx_cycle(8'h00);
        check("filt_par_cnt", par_err_cnt, 1);
        check("filt_frm_cnt", frm_err_cnt, 0);
        check("filt_drained", exp_q.size(), 0);

        reset_dut();
        force_full = 1'b1;
        rx_done = 1'b1;
        repeat (300) rx_cycle(8'($urandom));
        rx_done = 1'b0;
        force_full = 1'b0;
        check("ovf_sat", ovf_cnt, 255);
        check("ovf_model", ovf_cnt, e_ovf);
        check("ovf_no_write", rx_q.size(), 0);

        reset_dut();
        s_valid = 1'b1;
        s_data = 8'hA5;
        tx_cycle();
        s_data = 8'h3C;
        tx_cycle();
        s_valid = 1'b0;
        repeat (30) tx_cycle();
        check("tx_wr_cnt", wr_c.size(), 2);
        check("tx_rd_cnt", rd_c.size(), 2);
        check("tx_start_cnt", st_c.size(), 2);
        check("tx_done_seen", dn_c.size() >= 1, 1);
        if (rd_c.size() == 2 && st_c.size() == 2 && dn_c.size() > 0 && wr_c.size() > 0) begin
            check("tx_launch_lat", st_c[0] - (wr_c[0] + 1), 3);
            check("tx_pop_start0", st_c[0] - rd_c[0], 2);
            check("tx_pop_start1", st_c[1] - rd_c[1], 2);
            check("tx_gap_spacing", st_c[1] - dn_c[0], 7);
        end

        reset_dut();
        force_full = 1'b1; rx_done = 1'b1; framing_error_flag = 1'b1; parity_error_flag = 1'b1;
        rx_cycle(8'h00);
        force_full = 1'b0; rx_done = 1'b0; framing_error_flag = 1'b0; parity_error_flag = 1'b0;
        check("pre_rst_ovf", ovf_cnt, 1);
        check("pre_rst_frm", frm_err_cnt, 1);
        cyc = 0;
        wr_c.delete(); rd_c.delete(); st_c.delete(); dn_c.delete();
        s_valid = 1'b1;
        s_data = 8'h99;
        tx_cycle();
        s_valid = 1'b0;
        repeat (3) tx_cycle();
        check("pre_rst_start", tx_start, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid_tx");
        tx_q.delete();
        tx_q.push_back(8'h77);
        tx_busy = 1'b0; tx_done = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        cyc = 0;
        wr_c.delete(); rd_c.delete(); st_c.delete(); dn_c.delete();
        repeat (6) tx_cycle();
        check("relaunch_rd_cnt", rd_c.size(), 1);
        check("relaunch_start_cnt", st_c.size(), 1);
        if (rd_c.size() == 1 && st_c.size() == 1) begin
            check("relaunch_rd_cyc", rd_c[0], 1);
            check("relaunch_start_cyc", st_c[0], 3);
        end

        reset_dut();
        for (int n = 0; n < 800; n++) begin
            rx_done = $urandom_range(0, 2) == 0;
            framing_error_flag = $urandom_range(0, 3) == 0;
            parity_error_flag = $urandom_range(0, 3) == 0;
            force_full = $urandom_range(0, 7) == 0;
            m_ready = $urandom_range(0, 3) != 0;
            rx_en = $urandom_range(0, 1) == 1;
            rx_cycle(8'($urandom));
        end
        rx_done = 1'b0; force_full = 1'b0; m_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) rx_cycle(8'h00);
        check("rand_drained", exp_q.size(), 0);
        check("rand_ovf", ovf_cnt, e_ovf);
        check("rand_frm", frm_err_cnt, e_frm);
        check("rand_par", par_err_cnt, e_par);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_host_ctrl.md
# uart_host_ctrl

Host-side sequencer that drives the FIFO and start/flag ports of `uart_top`. It accepts bytes from a valid/ready host stream and pushes them into the TX FIFO. It launches one TX frame per FIFO entry, arms reception, commits received bytes into the RX FIFO, and drains the RX FIFO to a valid/ready host output stream. It also keeps saturating error statistics.

## Interface
Parameters
- `data_wd`, 8: byte width; must match `uart_top`.
- `cnt_wd`, 8: width of each error counter.
- `tx_gap`, 0: idle clk cycles inserted after `tx_done` before the next `tx_start`. 0 means no gap.

Ports
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_en`  in  1  level; enables reception.
- `s_data`  in  data_wd  host byte to transmit.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `m_data`  out  data_wd  received byte to host.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  host accepts `m_data`.
- `tx_full`, `tx_empty`, `rx_full`, `rx_empty`, `tx_done`, `tx_busy`, `rx_done`, `framing_error_flag`, `parity_error_flag`  in  1 each  from `uart_top`.
- `dout`  in  data_wd  RX FIFO read data from `uart_top`.
- `din`  out  data_wd  to `uart_top`; equals `s_data`.
- `tx_wr_en`, `tx_rd_en`, `rx_wr_en`, `rx_rd_en`, `tx_start`, `rx_start`  out  1 each  to `uart_top`.
- `frm_err_cnt`, `par_err_cnt`, `ovf_cnt`  out  cnt_wd  saturating statistics.

## Operation
- **Reset values:** all outputs are 0, all counters are 0, and both FSMs are in their idle state.
- **Host ingress:** combinational path.
  - `s_ready = rst_n & ~tx_full`.
  - `tx_wr_en = s_valid & s_ready`.
  - `din = s_data`.
- **TX FSM** (states `T_IDLE`, `T_POP`, `T_LOAD`, `T_START`, `T_BUSY`, `T_GAP`):
  - `T_IDLE`: move to `T_POP` when `~tx_empty & ~tx_busy`.
  - `T_POP`: `tx_rd_en = 1` for exactly one cycle, then `T_LOAD`.
  - `T_LOAD`: one cycle for the FIFO read data to settle, then `T_START`.
  - `T_START`: `tx_start = 1` for one cycle, then `T_BUSY`.
  - `T_BUSY`: wait for `tx_done`, then go to `T_GAP` if `tx_gap > 0`, else `T_IDLE`.
  - `T_GAP`: count `tx_gap` cycles, then `T_IDLE`.
- **RX arm:** `rx_start` is registered `rx_en`, i.e. it follows `rx_en` with one cycle of delay.
- **RX commit:** on a cycle with `rx_done = 1`:
  - If `rx_full`: no write, and `ovf_cnt` increments.
  - Else if an error flag is set: handling depends on the Configuration macro.
  - Else: `rx_wr_en = 1` in the same cycle (combinational from `rx_done`).
  - `framing_error_flag` sampled with `rx_done` increments `frm_err_cnt`; `parity_error_flag` increments `par_err_cnt`. Both may increment in the same cycle.
- **RX egress:** one-entry output register.
  - When the register is empty or being consumed (`~m_valid | m_ready`), `~rx_empty`, and no read is in flight: pulse `rx_rd_en`.
  - On the next cycle, load `m_data <= dout` and set `m_valid`.
  - `m_valid` clears when `m_ready & ~reload`.
- **Counters:** saturate at `2^cnt_wd - 1` and never wrap.

## Timing
- **Ingress:** zero latency; a write occurs in the same cycle as the handshake.
- **TX launch:** FIFO non-empty with the FSM in `T_IDLE` gives `tx_start` 3 cycles later (`T_IDLE` → `T_POP` → `T_LOAD` → `T_START`).
- **Back-to-back TX:** the next `tx_start` comes at least `tx_gap + 4` cycles after `tx_done`.
- **Egress latency:** `rx_empty` falling gives `m_valid` 2 cycles later. Sustained throughput is one byte per 2 cycles.
- **Simultaneous push and pop:** a host push and a `tx_rd_en` in the same cycle are both legal; the FIFO handles them.
- **Stall:** `m_valid` held with `m_ready = 0` keeps `m_data` stable; no `rx_rd_en` is issued.
- **`rx_en` deassert mid-frame:** `rx_start` drops one cycle later. A frame completing afterwards is still committed.
- **Reset mid-operation:** all FSMs and counters return to reset values immediately. No partial strobe may be emitted after `rst_n` falls.

## Configuration
- Macro: `UART_HOST_ERR_FILTER_EN`.
- **Defined:** frames with `framing_error_flag` or `parity_error_flag` set at `rx_done` are dropped (no `rx_wr_en`). Counters still increment.
- **Undefined:** erroneous frames are written to the RX FIFO like good ones; only the counters record the error.

## Test plan
- **TX push and launch:** push 0xA5, 0x3C with `tx_empty` toggling as an ideal FIFO would.
  - Required: `tx_wr_en` twice; `tx_rd_en` then `tx_start` 2 cycles later for each byte.
  - Required: second `tx_start` exactly `tx_gap + 4` cycles after the first `tx_done`, checked with `tx_gap = 3`.
- **RX good byte:** `rx_done` with `dout = 0x5A`, no flags.
  - Required: `rx_wr_en` in the same cycle.
  - Required: after `rx_empty` falls, `rx_rd_en` then `m_valid` with `m_data = 0x5A`.
- **RX overflow:** `rx_done` while `rx_full = 1`, repeated 300 times with `cnt_wd = 8`.
  - Required: no `rx_wr_en`; `ovf_cnt` saturates at 255.
- **Error filter:** `rx_done` with `parity_error_flag = 1`.
  - With `UART_HOST_ERR_FILTER_EN`: no write, `par_err_cnt = 1`.
  - Without it: `rx_wr_en = 1`, `par_err_cnt = 1`.
- **Egress back-pressure:** hold `m_ready = 0` with `rx_empty = 0`.
  - Required: exactly one `rx_rd_en`; `m_data` stable.
  - Raising `m_ready` gives the next `rx_rd_en` in the same cycle.
- **Reset mid-TX:** assert `rst_n = 0` in `T_START`.
  - Required: `tx_start` is 0 asynchronously, and all outputs and counters are 0.
  - After release, the FSM is in `T_IDLE` and relaunches when `tx_empty = 0`.
